// File: rtl/axis_packet_rx_if.sv
// AXI4-Stream bus carrying the 32-bit packet stream into axis_packet_rx.
interface axis_packet_rx_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic [7:0]  tdest;
  logic [3:0]  tuser;

  modport master (output tvalid, tdata, tlast, tdest, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tdest, tuser, output tready);
endinterface

// File: rtl/axis_packet_rx.sv
// Store-and-forward AXIS packet receiver: validates packets and releases only complete ones.
// Optional packet/drop counters are enabled with `define AXIS_RX_STATS_EN.
module axis_packet_rx #(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axis_packet_rx_if.slave        s,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [31:0]            o_data,
  output logic                   o_sop,
  output logic                   o_eop,
  output logic                   err_sync,
  output logic                   err_hdr,
  output logic                   err_dest,
  output logic                   err_ovf
`ifdef AXIS_RX_STATS_EN
  ,
  output logic [31:0]            stat_pkts,
  output logic [31:0]            stat_drops
`endif
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 33;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state, state_n;
  logic [PW-1:0] wr_ptr, wr_n, commit_ptr, commit_n, rd_ptr, rd_n;
  logic [7:0]    dest_q, dest_n;
  logic          first_q, first_n;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rd_word;

  logic          accept, full, ovf, we, commit, load;
  logic          sync_set, hdr_set, dest_set, ovf_set;
  logic          valid_n, sop_n, eop_n, ready_n;
  logic [31:0]   data_n;
  logic [PW-1:0] used_n;
  logic          full_n, ovf_nx;
  logic          unused_tuser;

  assign unused_tuser = ^s.tuser[3:1];

  assign accept  = s.tvalid && s.tready;
  assign full    = (wr_ptr - rd_ptr) == DEPTH_P;
  // Packet already fills the whole FIFO on its own: it can never be committed.
  assign ovf     = (state == RECV) && full && ((wr_ptr - commit_ptr) == DEPTH_P);
  assign rd_word = mem[rd_ptr[AW-1:0]];

  always_comb begin
    state_n  = state;
    wr_n     = wr_ptr;
    commit_n = commit_ptr;
    dest_n   = dest_q;
    we       = 1'b0;
    commit   = 1'b0;
    sync_set = 1'b0;
    hdr_set  = 1'b0;
    dest_set = 1'b0;
    ovf_set  = 1'b0;

    if (accept) begin
      case (state)
        IDLE: begin
          if (!s.tuser[0]) begin
            sync_set = 1'b1;
            state_n  = s.tlast ? IDLE : DROP;
          end else if (s.tdata[31:24] != s.tdest) begin
            hdr_set = 1'b1;
            state_n = s.tlast ? IDLE : DROP;
          end else begin
            we     = 1'b1;
            dest_n = s.tdest;
            if (s.tlast) commit = 1'b1;
            else         state_n = RECV;
          end
        end
        RECV: begin
          if (ovf) begin
            ovf_set = 1'b1;
            wr_n    = commit_ptr;
            state_n = s.tlast ? IDLE : DROP;
          end else if (s.tuser[0] || (s.tdest != dest_q)) begin
            dest_set = 1'b1;
            wr_n     = commit_ptr;
            state_n  = s.tlast ? IDLE : DROP;
          end else begin
            we = 1'b1;
            if (s.tlast) begin
              commit  = 1'b1;
              state_n = IDLE;
            end
          end
        end
        DROP: begin
          if (s.tlast) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    if (we)     wr_n     = wr_ptr + PW'(1);
    if (commit) commit_n = wr_ptr + PW'(1);

    // Output slot refills from committed data whenever it is empty or being drained.
    load    = (rd_ptr != commit_ptr) && (!o_valid || o_ready);
    rd_n    = rd_ptr;
    valid_n = o_valid && !o_ready;
    data_n  = o_data;
    sop_n   = o_sop;
    eop_n   = o_eop;
    first_n = first_q;
    if (load) begin
      rd_n    = rd_ptr + PW'(1);
      valid_n = 1'b1;
      data_n  = rd_word[31:0];
      eop_n   = rd_word[32];
      sop_n   = first_q;
      first_n = rd_word[32];
    end

    used_n  = wr_n - rd_n;
    full_n  = (used_n == DEPTH_P);
    ovf_nx  = (state_n == RECV) && full_n && ((wr_n - commit_n) == DEPTH_P);
    ready_n = (state_n == DROP) || !full_n || ovf_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      dest_q     <= '0;
      first_q    <= 1'b1;
      s.tready   <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_sop      <= 1'b0;
      o_eop      <= 1'b0;
      err_sync   <= 1'b0;
      err_hdr    <= 1'b0;
      err_dest   <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_n;
      commit_ptr <= commit_n;
      rd_ptr     <= rd_n;
      dest_q     <= dest_n;
      first_q    <= first_n;
      s.tready   <= ready_n;
      o_valid    <= valid_n;
      o_data     <= data_n;
      o_sop      <= sop_n;
      o_eop      <= eop_n;
      err_sync   <= sync_set;
      err_hdr    <= hdr_set;
      err_dest   <= dest_set;
      err_ovf    <= ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr[AW-1:0]] <= {s.tlast, s.tdata};
  end

`ifdef AXIS_RX_STATS_EN
  // Saturating counters of committed packets and dropped (flagged) packets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_pkts  <= '0;
      stat_drops <= '0;
    end else begin
      if (commit && (stat_pkts != 32'hFFFF_FFFF))
        stat_pkts <= stat_pkts + 32'd1;
      if ((sync_set || hdr_set || dest_set || ovf_set) && (stat_drops != 32'hFFFF_FFFF))
        stat_drops <= stat_drops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_packet_rx.sv
// Directed self-checking bench for axis_packet_rx built with DEPTH=4.
module tb_axis_packet_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_valid, o_ready, o_sop, o_eop;
  logic [31:0] o_data;
  logic        err_sync, err_hdr, err_dest, err_ovf;

  int tests = 0;
  int failed = 0;
  int n_sync = 0, n_hdr = 0, n_dest = 0, n_ovf = 0;
  logic [33:0] outq[$];

  axis_packet_rx_if bus ();

  axis_packet_rx #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (bus),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_sop    (o_sop),
    .o_eop    (o_eop),
    .err_sync (err_sync),
    .err_hdr  (err_hdr),
    .err_dest (err_dest),
    .err_ovf  (err_ovf)
  );

  always #5 clk = ~clk;

  // Capture delivered words and error pulses away from the active edge.
  always @(negedge clk) begin
    if (o_valid && o_ready) outq.push_back({o_sop, o_eop, o_data});
    if (err_sync) n_sync++;
    if (err_hdr)  n_hdr++;
    if (err_dest) n_dest++;
    if (err_ovf)  n_ovf++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_errs(input string tag, input int s, input int h, input int d, input int o);
    chk(tag, 64'({16'(n_sync), 16'(n_hdr), 16'(n_dest), 16'(n_ovf)}),
             64'({16'(s), 16'(h), 16'(d), 16'(o)}));
  endtask

  task automatic expect_word(input string tag, input logic sop, input logic eop, input logic [31:0] d);
    logic [33:0] w;
    tests++;
    if (outq.size() == 0) begin
      failed++;
      $error("FAIL %s: observed no word expected 0x%0h", tag, {sop, eop, d});
    end else begin
      tests--;
      w = outq.pop_front();
      chk(tag, 64'(w), 64'({sop, eop, d}));
    end
  endtask

  // Drive one beat and hold it until the handshake edge; returns #1 after that edge.
  task automatic send(input logic [31:0] d, input logic [7:0] dst, input logic first, input logic last);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    bus.tvalid = 1'b1;
    bus.tdata  = d;
    bus.tdest  = dst;
    bus.tuser  = {3'b000, first};
    bus.tlast  = last;
    while (!done) begin
      @(negedge clk);
      if (bus.tready) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 100) begin
        tests++;
        failed++;
        $error("FAIL send_timeout: observed tready 0 expected 1 for beat 0x%0h", d);
        done = 1'b1;
      end
    end
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.tvalid = 1'b0;
    bus.tdata  = '0;
    bus.tlast  = 1'b0;
    bus.tdest  = '0;
    bus.tuser  = '0;
    o_ready    = 1'b1;
    rst_n      = 1'b0;

    // Reset state
    idle(3);
    chk("rst_tready", bus.tready, 1'b0);
    chk("rst_out", {o_valid, o_sop, o_eop, o_data}, 35'd0);
    chk("rst_err", {err_sync, err_hdr, err_dest, err_ovf}, 4'd0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_tready", bus.tready, 1'b1);

    // Valid 3-beat packet and output latency
    send(32'h05000001, 8'h05, 1'b1, 1'b0);
    send(32'hAABBCCDD, 8'h05, 1'b0, 1'b0);
    send(32'h12345678, 8'h05, 1'b0, 1'b1);
    chk("t1_lat_early", o_valid, 1'b0);
    idle(1);
    chk("t1_lat", o_valid, 1'b1);
    chk("t1_first", {o_sop, o_eop, o_data}, {2'b10, 32'h05000001});
    idle(6);
    expect_word("t1_w0", 1'b1, 1'b0, 32'h05000001);
    expect_word("t1_w1", 1'b0, 1'b0, 32'hAABBCCDD);
    expect_word("t1_w2", 1'b0, 1'b1, 32'h12345678);
    chk("t1_qempty", outq.size(), 0);
    chk_errs("t1_errs", 0, 0, 0, 0);

    // Header/TDEST mismatch
    send(32'h07000000, 8'h05, 1'b1, 1'b0);
    chk("t2_hdr_pulse", err_hdr, 1'b1);
    chk("t2_tready_drop", bus.tready, 1'b1);
    send(32'h11111111, 8'h05, 1'b0, 1'b1);
    chk("t2_hdr_off", err_hdr, 1'b0);
    idle(6);
    chk("t2_qempty", outq.size(), 0);
    chk_errs("t2_errs", 0, 1, 0, 0);

    // A good, B changes TDEST mid-packet, C good
    send(32'h05000010, 8'h05, 1'b1, 1'b0);
    send(32'h000000A1, 8'h05, 1'b0, 1'b1);
    send(32'h05000020, 8'h05, 1'b1, 1'b0);
    send(32'h000000B1, 8'h05, 1'b0, 1'b0);
    send(32'h000000B2, 8'h06, 1'b0, 1'b0);
    chk("t3_dest_pulse", err_dest, 1'b1);
    send(32'h000000B3, 8'h06, 1'b0, 1'b1);
    send(32'h05000030, 8'h05, 1'b1, 1'b0);
    send(32'h000000C1, 8'h05, 1'b0, 1'b1);
    idle(8);
    expect_word("t3_a0", 1'b1, 1'b0, 32'h05000010);
    expect_word("t3_a1", 1'b0, 1'b1, 32'h000000A1);
    expect_word("t3_c0", 1'b1, 1'b0, 32'h05000030);
    expect_word("t3_c1", 1'b0, 1'b1, 32'h000000C1);
    chk("t3_qempty", outq.size(), 0);
    chk_errs("t3_errs", 0, 1, 1, 0);

    // Overflow: 6-beat packet into a 4-word FIFO
    send(32'h05000040, 8'h05, 1'b1, 1'b0);
    send(32'h00000041, 8'h05, 1'b0, 1'b0);
    send(32'h00000042, 8'h05, 1'b0, 1'b0);
    send(32'h00000043, 8'h05, 1'b0, 1'b0);
    chk("t4_no_ovf_yet", err_ovf, 1'b0);
    send(32'h00000044, 8'h05, 1'b0, 1'b0);
    chk("t4_ovf_pulse", err_ovf, 1'b1);
    send(32'h00000045, 8'h05, 1'b0, 1'b1);
    send(32'h05000050, 8'h05, 1'b1, 1'b0);
    send(32'h00000051, 8'h05, 1'b0, 1'b1);
    idle(6);
    expect_word("t4_u0", 1'b1, 1'b0, 32'h05000050);
    expect_word("t4_u1", 1'b0, 1'b1, 32'h00000051);
    chk("t4_qempty", outq.size(), 0);
    chk_errs("t4_errs", 0, 1, 1, 1);

    // Backpressure: two 3-beat packets with o_ready low
    o_ready = 1'b0;
    send(32'h05000060, 8'h05, 1'b1, 1'b0);
    send(32'h00000061, 8'h05, 1'b0, 1'b0);
    send(32'h00000062, 8'h05, 1'b0, 1'b1);
    send(32'h05000070, 8'h05, 1'b1, 1'b0);
    send(32'h00000071, 8'h05, 1'b0, 1'b0);
    bus.tvalid = 1'b1;
    bus.tdata  = 32'h00000072;
    bus.tdest  = 8'h05;
    bus.tuser  = 4'b0000;
    bus.tlast  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("t5_stall", bus.tready, 1'b0);
    end
    chk("t5_held", {o_valid, o_sop, o_eop, o_data}, {3'b110, 32'h05000060});
    chk("t5_qempty", outq.size(), 0);
    o_ready = 1'b1;
    send(32'h00000072, 8'h05, 1'b0, 1'b1);
    idle(10);
    expect_word("t5_p0", 1'b1, 1'b0, 32'h05000060);
    expect_word("t5_p1", 1'b0, 1'b0, 32'h00000061);
    expect_word("t5_p2", 1'b0, 1'b1, 32'h00000062);
    expect_word("t5_q0", 1'b1, 1'b0, 32'h05000070);
    expect_word("t5_q1", 1'b0, 1'b0, 32'h00000071);
    expect_word("t5_q2", 1'b0, 1'b1, 32'h00000072);
    chk("t5_qempty2", outq.size(), 0);
    chk_errs("t5_errs", 0, 1, 1, 1);

    // Reset mid-packet with a committed, unread packet
    o_ready = 1'b0;
    send(32'h05000080, 8'h05, 1'b1, 1'b0);
    send(32'h00000081, 8'h05, 1'b0, 1'b1);
    idle(3);
    chk("t6_pending", o_valid, 1'b1);
    send(32'h05000090, 8'h05, 1'b1, 1'b0);
    rst_n = 1'b0;
    idle(1);
    chk("t6_rst_valid", o_valid, 1'b0);
    chk("t6_rst_tready", bus.tready, 1'b0);
    rst_n   = 1'b1;
    o_ready = 1'b1;
    idle(5);
    chk("t6_nothing", outq.size(), 0);
    send(32'h050000A0, 8'h05, 1'b1, 1'b0);
    send(32'h000000A1, 8'h05, 1'b0, 1'b1);
    idle(6);
    expect_word("t6_t0", 1'b1, 1'b0, 32'h050000A0);
    expect_word("t6_t1", 1'b0, 1'b1, 32'h000000A1);
    chk("t6_qempty", outq.size(), 0);
    chk_errs("t6_errs", 0, 1, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
